// File: rtl/bus_state_pkg.sv
// Shared widths and bus field types for the bus state master and its counter.
package bus_state_pkg;

    localparam int STATE_W = 3;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;

    // Highest state value; the counter wraps back to zero after it.
    localparam state_t MAX_STATE = '1;

endpackage

// File: rtl/state_wrap_counter.sv
// Free-running modulo-2**STATE_W bus phase counter with an enable and a
// combinational strobe that marks the edge on which the count rolls over.
module state_wrap_counter
    import bus_state_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [STATE_W-1:0] state,
    output logic               wrapStrobe
);

    state_t r_state;

    // Advance the phase count on every enabled edge; reset takes priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (en) begin
            r_state <= r_state + 1'b1;
        end
    end

    assign state      = r_state;
    assign wrapStrobe = en && (r_state == MAX_STATE);

endmodule

// File: rtl/bus_state_master.sv
// Master-side driver for the shared address/data bus. Publishes the phase
// counter as the bus state and address, and counts counter wraps on the data
// lines. Optional feature macro: WRAP_PULSE_EN adds a registered one-cycle
// wrap output that rises together with the data increment.
module bus_state_master
    import bus_state_pkg::*;
#(
    parameter int DATA_STEP = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [STATE_W-1:0] state,
    output logic [ADDR_W-1:0]  address,
    output logic [DATA_W-1:0]  data,
    output logic               valid
`ifdef WRAP_PULSE_EN
    ,
    output logic               wrap
`endif
);

    localparam data_t STEP = data_t'(DATA_STEP);

    state_t w_state;
    logic   w_wrapStrobe;
    data_t  r_data;
    logic   r_valid;

    state_wrap_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .state      (w_state),
        .wrapStrobe (w_wrapStrobe)
    );

    // Data counts counter wraps in units of STEP, rolling over silently at full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_wrapStrobe) begin
            r_data <= r_data + STEP;
        end
    end

    // The bus is considered driven from the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
        end
    end

`ifdef WRAP_PULSE_EN
    logic r_wrap;

    // Pulse is registered on the same edge as the data increment so both change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrapStrobe;
        end
    end

    assign wrap = r_wrap;
`endif

    assign state   = w_state;
    assign address = addr_t'(w_state);
    assign data    = r_data;
    assign valid   = r_valid;

endmodule

// File: tb/tb_bus_state_master.sv
// Self-checking bench for bus_state_master: directed vector table, hand
// sequences for hold/reset/wrap corners, and randomized traffic compared
// against an enabled-edge-count model. A second instance uses DATA_STEP=3.
module tb_bus_state_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] state,   state3;
    logic [7:0] address, address3;
    logic [7:0] data,    data3;
    logic       valid,   valid3;
`ifdef WRAP_PULSE_EN
    logic       wrap,    wrap3;
`endif

    int numChecks = 0;
    int numFails  = 0;

    // Model: number of enabled edges since the last reset determines everything.
    int   mCount = 0;
    logic mValid = 1'b0;
    logic mWrap  = 1'b0;

    typedef struct {
        logic rst;
        logic en;
        int   expState;
        int   expData;
        logic expValid;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    bus_state_master #(.DATA_STEP(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .state   (state),
        .address (address),
        .data    (data),
        .valid   (valid)
`ifdef WRAP_PULSE_EN
        ,
        .wrap    (wrap)
`endif
    );

    bus_state_master #(.DATA_STEP(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .state   (state3),
        .address (address3),
        .data    (data3),
        .valid   (valid3)
`ifdef WRAP_PULSE_EN
        ,
        .wrap    (wrap3)
`endif
    );

    // Drive one clock edge with the given inputs and advance the model.
    task automatic applyStimulus(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        if (r) begin
            mCount = 0;
            mValid = 1'b0;
            mWrap  = 1'b0;
        end else begin
            mValid = 1'b1;
            if (e) begin
                mCount = mCount + 1;
                mWrap  = ((mCount % 8) == 0);
            end else begin
                mWrap = 1'b0;
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare both instances against the model's view of the bus.
    task automatic checkOutput(input string tag);
        checkValue({tag, " state"},    state,    mCount % 8);
        checkValue({tag, " address"},  address,  mCount % 8);
        checkValue({tag, " data"},     data,     (mCount / 8) % 256);
        checkValue({tag, " valid"},    valid,    mValid);
        checkValue({tag, " state3"},   state3,   mCount % 8);
        checkValue({tag, " address3"}, address3, mCount % 8);
        checkValue({tag, " data3"},    data3,    ((mCount / 8) * 3) % 256);
        checkValue({tag, " valid3"},   valid3,   mValid);
`ifdef WRAP_PULSE_EN
        checkValue({tag, " wrap"},     wrap,     mWrap);
        checkValue({tag, " wrap3"},    wrap3,    mWrap);
`endif
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;

        // Three reset edges (one with en=1 to show reset wins), then ten enabled edges.
        vecs[0]  = '{1'b1, 1'b0, 0, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1, 0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2, 0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3, 0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4, 0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 5, 0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 6, 0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 7, 0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 0, 1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1, 1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2, 1, 1'b1};

        $display("[TB] directed vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en);
            checkValue($sformatf("vec%0d state", i),   state,   vecs[i].expState);
            checkValue($sformatf("vec%0d address", i), address, vecs[i].expState);
            checkValue($sformatf("vec%0d data", i),    data,    vecs[i].expData);
            checkValue($sformatf("vec%0d valid", i),   valid,   vecs[i].expValid);
        end

        $display("[TB] hold with en=0 at state 5");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        checkValue("pre-hold state", state, 5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkValue($sformatf("hold%0d state", i), state, 5);
            checkValue($sformatf("hold%0d data", i),  data,  0);
            checkValue($sformatf("hold%0d valid", i), valid, 1);
        end
        applyStimulus(1'b0, 1'b1);
        checkValue("resume state", state, 6);

        $display("[TB] reset asserted mid-count at state 6");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1);
        checkValue("pre-reset state", state, 6);
        checkValue("pre-reset data",  data,  1);
        applyStimulus(1'b1, 1'b1);
        checkValue("mid-reset state",   state,   0);
        checkValue("mid-reset data",    data,    0);
        checkValue("mid-reset valid",   valid,   0);
        checkValue("mid-reset address", address, 0);
        checkValue("mid-reset data3",   data3,   0);

        $display("[TB] data after 7, 8 and 16 enabled edges");
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 7)  checkValue("run7 data",  data, 0);
            if (i == 8)  checkValue("run8 data",  data, 1);
            if (i == 16) checkValue("run16 data", data, 2);
        end

        $display("[TB] en toggling on the max state");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
        checkValue("at-max state", state, 7);
        applyStimulus(1'b0, 1'b0);
        checkValue("max-held state", state, 7);
        checkValue("max-held data",  data,  0);
`ifdef WRAP_PULSE_EN
        checkValue("max-held wrap",  wrap,  0);
`endif
        applyStimulus(1'b0, 1'b1);
        checkValue("max-wrap state", state, 0);
        checkValue("max-wrap data",  data,  1);
`ifdef WRAP_PULSE_EN
        checkValue("max-wrap wrap",  wrap,  1);
`endif
        applyStimulus(1'b0, 1'b1);
        checkValue("post-wrap data", data, 1);
`ifdef WRAP_PULSE_EN
        checkValue("post-wrap wrap", wrap, 0);
`endif

        $display("[TB] DATA_STEP=3 after 24 enabled edges");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1);
        checkValue("step3 data", data3, 9);
        checkValue("step1 data", data,  3);

        $display("[TB] randomized traffic against model");
        applyStimulus(1'b1, 1'b0);
        checkOutput("rand-reset");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("[TB] long run: data rolls over at full width");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6000; i++) applyStimulus(1'b0, 1'b1);
        checkValue("long data",  data,  238);
        checkValue("long data3", data3, 202);
        checkValue("long state", state, 0);
        checkOutput("long");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
